// File: rtl/mvu_pkg.sv
// Shared MVU geometry constants used by the data-memory write path.
package mvu_pkg;
    localparam int NMVU    = 8;
    localparam int BDBANKA = 15;
    localparam int BDBANKW = 64;
endpackage

// File: rtl/mvu_wrc_arbiter_pkg.sv
// Helpers for the write-port arbiter; re-uses the MVU geometry from mvu_pkg.
package mvu_wrc_arbiter_pkg;
    import mvu_pkg::*;

    localparam int STALL_W = 16;

    // Index wrap for the round-robin scan; idx is always below 2*n.
    function automatic int rr_wrap(input int idx, input int n);
        return (idx >= n) ? idx - n : idx;
    endfunction
endpackage

// File: rtl/mvu_wrc_arbiter_if.sv
// Requester-side and MVU-side write bus of the arbiter.
interface mvu_wrc_arbiter_if
    import mvu_pkg::*;
#(
    parameter int NREQ   = NMVU,
    parameter int ADDR_W = BDBANKA,
    parameter int DATA_W = BDBANKW
);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_word;
    logic [NREQ-1:0]        wrc_en;
    logic [ADDR_W-1:0]      wrc_addr;
    logic [DATA_W-1:0]      wrc_word;
    logic [NREQ-1:0]        wrc_grnt;

    // master: transposers plus MVU grant source; slave: the arbiter
    modport master (
        output req_valid, req_addr, req_word, wrc_grnt,
        input  req_ready, wrc_en, wrc_addr, wrc_word
    );
    modport slave (
        input  req_valid, req_addr, req_word, wrc_grnt,
        output req_ready, wrc_en, wrc_addr, wrc_word
    );
endinterface

// File: rtl/mvu_wrc_arbiter_fifo.sv
// Per-requester synchronous FIFO; the head word is visible while not empty.
module wrc_req_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);
    logic [W-1:0]  mem [DEPTH];
    logic [CW-1:0] wr_ptr;
    logic [CW-1:0] rd_ptr;

    assign count = wr_ptr - rd_ptr;
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/mvu_wrc_arbiter.sv
// Round-robin arbiter feeding the single MVU data-memory write port from
// NREQ buffered requesters through one registered output stage.
module mvu_wrc_arbiter
    import mvu_pkg::*;
    import mvu_wrc_arbiter_pkg::*;
#(
    parameter int NREQ   = NMVU,
    parameter int ADDR_W = BDBANKA,
    parameter int DATA_W = BDBANKW,
    parameter int DEPTH  = 4
) (
    input  logic               clk,
    input  logic               rst,
    mvu_wrc_arbiter_if.slave   bus,
    output logic               idle,
    output logic [STALL_W-1:0] stall_cnt
);
    localparam int SEL_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int W     = ADDR_W + DATA_W;

    logic [NREQ-1:0] fifo_empty, fifo_full, push, pop;
    logic [W-1:0]    head  [NREQ];
    logic [CW-1:0]   count [NREQ];

    logic [NREQ-1:0]   en_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] word_q;
    logic [SEL_W-1:0]  rr_ptr;

    logic              complete, load, found, any_cnt;
    logic [SEL_W-1:0]  winner;
    logic [2*NREQ-1:0] dbl, shifted;
    logic [NREQ-1:0]   rot;

    for (genvar i = 0; i < NREQ; i++) begin : g_fifo
        wrc_req_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[i]),
            .pop   (pop[i]),
            .din   ({bus.req_addr[i*ADDR_W +: ADDR_W], bus.req_word[i*DATA_W +: DATA_W]}),
            .head  (head[i]),
            .count (count[i]),
            .empty (fifo_empty[i]),
            .full  (fifo_full[i])
        );
        assign push[i] = bus.req_valid[i] & ~fifo_full[i];
        assign pop[i]  = load & found & (winner == SEL_W'(i));
    end

    assign bus.req_ready = ~fifo_full;
    assign bus.wrc_en    = en_q;
    assign bus.wrc_addr  = addr_q;
    assign bus.wrc_word  = word_q;

    assign complete = |(en_q & bus.wrc_grnt);
    assign load     = ~(|en_q) | complete;

    // Rotate so the slot after rr_ptr sits at bit 0, pick the lowest, map back.
    always_comb begin
        dbl     = {~fifo_empty, ~fifo_empty};
        shifted = dbl >> (int'(rr_ptr) + 1);
        rot     = shifted[NREQ-1:0];
        found   = 1'b0;
        winner  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found  = 1'b1;
                winner = SEL_W'(rr_wrap(int'(rr_ptr) + 1 + k, NREQ));
            end
        end
    end

    always_comb begin
        any_cnt = 1'b0;
        for (int i = 0; i < NREQ; i++) any_cnt = any_cnt | (|count[i]);
        idle = ~any_cnt & ~(|en_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q      <= '0;
            addr_q    <= '0;
            word_q    <= '0;
            rr_ptr    <= SEL_W'(NREQ - 1);
            stall_cnt <= '0;
        end else begin
            if ((|en_q) && !complete && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if (load) begin
                if (found) begin
                    en_q             <= NREQ'(1) << winner;
                    {addr_q, word_q} <= head[winner];
                    rr_ptr           <= winner;
                end else begin
                    en_q <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_mvu_wrc_arbiter.sv
// Directed bench for the MVU write-port arbiter with hand-computed expectations.
module tb_mvu_wrc_arbiter;
    import mvu_pkg::*;

    localparam int NREQ   = NMVU;
    localparam int ADDR_W = BDBANKA;
    localparam int DATA_W = BDBANKW;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        idle;
    logic [15:0] stall_cnt;
    int          passes = 0;
    int          total  = 0;

    mvu_wrc_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mvu_wrc_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .idle      (idle),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] w);
        bus.req_addr[i*ADDR_W +: ADDR_W] = a;
        bus.req_word[i*DATA_W +: DATA_W] = w;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_word  = '0;
        bus.wrc_grnt  = '0;
        do_reset();

        // reset values
        chk("rst_en", 64'(bus.wrc_en), 64'h0);
        chk("rst_addr", 64'(bus.wrc_addr), 64'h0);
        chk("rst_word", bus.wrc_word, 64'h0);
        chk("rst_ready", 64'(bus.req_ready), 64'hFF);
        chk("rst_idle", 64'(idle), 64'h1);
        chk("rst_stall", 64'(stall_cnt), 64'h0);

        // single write on requester 3
        bus.wrc_grnt = '1;
        set_req(3, 15'h10, 64'hA5A5);
        bus.req_valid = 8'h08;
        step();
        bus.req_valid = '0;
        chk("single_no_bypass", 64'(bus.wrc_en), 64'h0);
        chk("single_busy", 64'(idle), 64'h0);
        step();
        chk("single_en", 64'(bus.wrc_en), 64'h08);
        chk("single_addr", 64'(bus.wrc_addr), 64'h10);
        chk("single_word", bus.wrc_word, 64'hA5A5);
        step();
        chk("single_en_off", 64'(bus.wrc_en), 64'h0);
        chk("single_idle", 64'(idle), 64'h1);

        // round-robin over all eight requesters
        do_reset();
        bus.wrc_grnt = '1;
        for (int i = 0; i < NREQ; i++) set_req(i, ADDR_W'(16'h40 + i), DATA_W'(64'h100 + i));
        bus.req_valid = '1;
        step();
        bus.req_valid = '0;
        for (int k = 0; k < NREQ; k++) begin
            step();
            chk($sformatf("rr_en_%0d", k), 64'(bus.wrc_en), 64'(8'(1) << k));
            chk($sformatf("rr_addr_%0d", k), 64'(bus.wrc_addr), 64'h40 + 64'(k));
        end
        step();
        chk("rr_done_en", 64'(bus.wrc_en), 64'h0);
        chk("rr_done_idle", 64'(idle), 64'h1);

        // grant stall on requester 2
        do_reset();
        bus.wrc_grnt = '0;
        set_req(2, 15'h2C, 64'hBEEF);
        bus.req_valid = 8'h04;
        step();
        bus.req_valid = '0;
        step();
        chk("stall_en0", 64'(bus.wrc_en), 64'h04);
        chk("stall_cnt0", 64'(stall_cnt), 64'h0);
        for (int c = 1; c <= 5; c++) begin
            step();
            chk($sformatf("stall_hold_en_%0d", c), 64'(bus.wrc_en), 64'h04);
            chk($sformatf("stall_hold_addr_%0d", c), 64'(bus.wrc_addr), 64'h2C);
            chk($sformatf("stall_hold_word_%0d", c), bus.wrc_word, 64'hBEEF);
        end
        chk("stall_cnt5", 64'(stall_cnt), 64'h5);
        bus.wrc_grnt = '1;
        step();
        chk("stall_done_en", 64'(bus.wrc_en), 64'h0);
        chk("stall_cnt_final", 64'(stall_cnt), 64'h5);
        chk("stall_idle", 64'(idle), 64'h1);

        // FIFO full and back-pressure on requester 1
        do_reset();
        bus.wrc_grnt = '0;
        bus.req_valid = 8'h02;
        for (int n = 0; n < 5; n++) begin
            set_req(1, ADDR_W'(16'h20 + n), DATA_W'(64'h1000 + n));
            chk($sformatf("full_ready_%0d", n), 64'(bus.req_ready[1]), 64'h1);
            step();
        end
        set_req(1, 15'h25, 64'h1005);
        chk("full_ready_drop", 64'(bus.req_ready[1]), 64'h0);
        step();
        chk("full_ready_stays", 64'(bus.req_ready[1]), 64'h0);
        chk("full_or_en", 64'(bus.wrc_en), 64'h02);
        chk("full_or_addr", 64'(bus.wrc_addr), 64'h20);
        bus.req_valid = '0;
        bus.wrc_grnt = '1;
        chk("drain_word_0", bus.wrc_word, 64'h1000);
        for (int j = 1; j < 5; j++) begin
            step();
            chk($sformatf("drain_en_%0d", j), 64'(bus.wrc_en), 64'h02);
            chk($sformatf("drain_addr_%0d", j), 64'(bus.wrc_addr), 64'h20 + 64'(j));
            chk($sformatf("drain_word_%0d", j), bus.wrc_word, 64'h1000 + 64'(j));
        end
        step();
        chk("drain_end_en", 64'(bus.wrc_en), 64'h0);
        chk("drain_end_idle", 64'(idle), 64'h1);

        // reset in the middle of a burst
        do_reset();
        bus.wrc_grnt = '0;
        for (int i = 0; i < 3; i++) set_req(i, ADDR_W'(16'h60 + i), DATA_W'(64'h600 + i));
        bus.req_valid = 8'h07;
        step();
        step();
        bus.req_valid = '0;
        chk("mid_or_en", 64'(bus.wrc_en), 64'h01);
        rst = 1'b1;
        #1;
        chk("mid_async_en", 64'(bus.wrc_en), 64'h0);
        chk("mid_async_addr", 64'(bus.wrc_addr), 64'h0);
        chk("mid_async_ready", 64'(bus.req_ready), 64'hFF);
        bus.wrc_grnt = '1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_idle", 64'(idle), 64'h1);
        for (int c = 0; c < 4; c++) begin
            step();
            chk($sformatf("mid_no_stale_%0d", c), 64'(bus.wrc_en), 64'h0);
        end
        chk("mid_idle_after", 64'(idle), 64'h1);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
